// File: rtl/hazard_scoreboard_fwd.sv
// hazard_scoreboard_fwd: decode-stage RAW/WAW hazard detection with multi-stage forwarding
// and a per-register pending-write scoreboard for out-of-order long-latency completions.
module hazard_scoreboard_fwd #(
    parameter int XLEN   = 32,
    parameter int NSTAGE = 3,
    parameter int CW     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               rs1_D,
    input  logic [4:0]               rs2_D,
    input  logic                     use_rs1,
    input  logic                     use_rs2,
    input  logic [4:0]               rd_D,
    input  logic                     wen_D,
    input  logic                     long_D,
    input  logic                     issue_fire,
    input  logic                     flush,
    input  logic [NSTAGE-1:0]        stg_valid,
    input  logic [NSTAGE-1:0]        stg_wen,
    input  logic [5*NSTAGE-1:0]      stg_rd,
    input  logic [NSTAGE-1:0]        stg_data_ok,
    input  logic [XLEN*NSTAGE-1:0]   stg_data,
    input  logic                     lc_valid,
    input  logic [4:0]               lc_rd,
    input  logic [XLEN-1:0]          lc_data,
    output logic                     stall_D,
    output logic [XLEN-1:0]          fwd_rs1,
    output logic [XLEN-1:0]          fwd_rs2,
    output logic                     fwd_v_rs1,
    output logic                     fwd_v_rs2,
    output logic                     sb_busy_any,
    output logic [31:0]              stall_cnt
);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic [CW-1:0]        cnt_q [32];
    logic [CW-1:0]        cnt_d [32];
    logic [31:0]          stall_cnt_q;
    logic [1:0][4:0]      src;
    logic [1:0]           use_v, hit, fv, raw;
    logic [1:0][XLEN-1:0] fd;
    logic                 waw, full, inc, dec, busy;

    assign src   = {rs2_D, rs1_D};
    assign use_v = {use_rs2, use_rs1};

    // Youngest matching stage wins; the scoreboard is consulted only when no stage matches.
    always_comb begin
        hit = '0;
        fv  = '0;
        raw = '0;
        fd  = '0;
        for (int k = 0; k < 2; k++) begin
            if (use_v[k] && src[k] != 5'd0) begin
                for (int i = 0; i < NSTAGE; i++) begin
                    if (!hit[k] && stg_valid[i] && stg_wen[i] && stg_rd[i*5 +: 5] == src[k]) begin
                        hit[k] = 1'b1;
                        fv[k]  = stg_data_ok[i];
                        raw[k] = !stg_data_ok[i];
                        fd[k]  = stg_data_ok[i] ? stg_data[i*XLEN +: XLEN] : '0;
                    end
                end
                if (!hit[k] && cnt_q[src[k]] != '0) begin
                    fv[k]  = lc_valid && lc_rd == src[k];
                    raw[k] = !fv[k];
                    fd[k]  = fv[k] ? lc_data : '0;
                end
            end
        end
    end

    assign waw = wen_D && rd_D != 5'd0 && !long_D && cnt_q[rd_D] != '0 &&
                 !(lc_valid && lc_rd == rd_D && cnt_q[rd_D] == CW'(1));
    assign full    = wen_D && long_D && rd_D != 5'd0 && cnt_q[rd_D] == CMAX;
    assign stall_D = !flush && (|raw || waw || full);
    assign inc     = issue_fire && !flush && !stall_D && wen_D && long_D && rd_D != 5'd0;
    assign dec     = lc_valid && lc_rd != 5'd0 && cnt_q[lc_rd] != '0;

    assign fwd_rs1   = fd[0];
    assign fwd_rs2   = fd[1];
    assign fwd_v_rs1 = fv[0];
    assign fwd_v_rs2 = fv[1];

    always_comb begin
        cnt_d[0] = '0;
        busy     = 1'b0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r] + CW'(inc && rd_D == 5'(r)) - CW'(dec && lc_rd == 5'(r));
            busy     = busy | (cnt_q[r] != '0);
        end
    end

    assign sb_busy_any = busy;
    assign stall_cnt   = stall_cnt_q;

    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++)
            cnt_q[r] <= rst ? '0 : cnt_d[r];
        if (rst)
            stall_cnt_q <= '0;
        else if (stall_D && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// tb_hazard_scoreboard_fwd: directed and randomized checks of hazard_scoreboard_fwd against a
// pending-write list model of the hazard rules.
module tb_hazard_scoreboard_fwd;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_D, rs2_D, rd_D, lc_rd;
    logic        use_rs1, use_rs2, wen_D, long_D, issue_fire, flush, lc_valid;
    logic [2:0]  stg_valid, stg_wen, stg_data_ok;
    logic [14:0] stg_rd;
    logic [95:0] stg_data;
    logic [31:0] lc_data;
    logic        stall_D, fwd_v_rs1, fwd_v_rs2, sb_busy_any;
    logic [31:0] fwd_rs1, fwd_rs2, stall_cnt;

    int          n_chk = 0, n_fail = 0;
    logic [4:0]  pend[$];
    logic [31:0] m_stall_cnt;
    logic        e_stall;

    hazard_scoreboard_fwd #(.XLEN(32), .NSTAGE(3), .CW(2)) dut (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd_D(rd_D), .wen_D(wen_D), .long_D(long_D), .issue_fire(issue_fire), .flush(flush),
        .stg_valid(stg_valid), .stg_wen(stg_wen), .stg_rd(stg_rd), .stg_data_ok(stg_data_ok),
        .stg_data(stg_data), .lc_valid(lc_valid), .lc_rd(lc_rd), .lc_data(lc_data),
        .stall_D(stall_D), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_v_rs1(fwd_v_rs1),
        .fwd_v_rs2(fwd_v_rs2), .sb_busy_any(sb_busy_any), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input logic [4:0] r);
        int c = 0;
        foreach (pend[j]) if (pend[j] == r) c++;
        return c;
    endfunction

    function automatic void model_src(input logic [4:0] s, input logic u, output logic v,
                                      output logic [31:0] d, output logic st);
        v = 1'b0; d = '0; st = 1'b0;
        if (!u || s == 5'd0) return;
        for (int i = 0; i < 3; i++)
            if (stg_valid[i] && stg_wen[i] && stg_rd[i*5 +: 5] == s) begin
                if (stg_data_ok[i]) begin v = 1'b1; d = stg_data[i*32 +: 32]; end
                else st = 1'b1;
                return;
            end
        if (cnt_of(s) > 0) begin
            if (lc_valid && lc_rd == s) begin v = 1'b1; d = lc_data; end
            else st = 1'b1;
        end
    endfunction

    task automatic idle();
        rst = 0; rs1_D = 0; rs2_D = 0; use_rs1 = 0; use_rs2 = 0; rd_D = 0; wen_D = 0;
        long_D = 0; issue_fire = 0; flush = 0; stg_valid = 0; stg_wen = 0; stg_rd = 0;
        stg_data_ok = 0; stg_data = 0; lc_valid = 0; lc_rd = 0; lc_data = 0;
    endtask

    task automatic settle();
        logic v1, v2, s1, s2, waw, full;
        logic [31:0] d1, d2;
        int c;
        #1;
        model_src(rs1_D, use_rs1, v1, d1, s1);
        model_src(rs2_D, use_rs2, v2, d2, s2);
        c = cnt_of(rd_D);
        waw  = wen_D && rd_D != 0 && !long_D && c > 0 && !(lc_valid && lc_rd == rd_D && c == 1);
        full = wen_D && long_D && rd_D != 0 && c == 3;
        e_stall = !flush && (s1 || s2 || waw || full);
        chk("stall_D", 32'(stall_D), 32'(e_stall));
        chk("fwd_v_rs1", 32'(fwd_v_rs1), 32'(v1));
        chk("fwd_rs1", fwd_rs1, d1);
        chk("fwd_v_rs2", 32'(fwd_v_rs2), 32'(v2));
        chk("fwd_rs2", fwd_rs2, d2);
        chk("sb_busy_any", 32'(sb_busy_any), 32'(pend.size() != 0));
        chk("stall_cnt", stall_cnt, m_stall_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_stall_cnt = 0;
        end else begin
            if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (lc_valid && lc_rd != 0)
                foreach (pend[j]) if (pend[j] == lc_rd) begin pend.delete(j); break; end
            if (issue_fire && !flush && !e_stall && wen_D && long_D && rd_D != 0)
                pend.push_back(rd_D);
        end
        @(negedge clk);
    endtask

    task automatic load_use();
        idle();
        stg_valid = 3'b001; stg_wen = 3'b001; stg_rd[0 +: 5] = 5'd7;
        rs2_D = 7; use_rs2 = 1;
    endtask

    task automatic long_issue(input logic [4:0] r);
        idle();
        rd_D = r; wen_D = 1; long_D = 1; issue_fire = 1;
    endtask

    task automatic complete(input logic [4:0] r, input logic [31:0] d);
        idle();
        lc_valid = 1; lc_rd = r; lc_data = d;
    endtask

    initial begin
        idle();
        rst = 1;
        m_stall_cnt = 0;
        e_stall = 0;
        advance();
        idle(); settle();
        chk("rst_busy", 32'(sb_busy_any), 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        advance();
        // stage 0 must win over the older stage 2 writing the same register
        idle();
        stg_valid = 3'b101; stg_wen = 3'b101; stg_data_ok = 3'b101;
        stg_rd[0 +: 5] = 5; stg_rd[10 +: 5] = 5;
        stg_data[0 +: 32] = 32'h11; stg_data[64 +: 32] = 32'h22;
        rs1_D = 5; use_rs1 = 1;
        settle();
        chk("alu_fwd_v", 32'(fwd_v_rs1), 1);
        chk("alu_fwd", fwd_rs1, 32'h11);
        chk("alu_stall", 32'(stall_D), 0);
        advance();
        load_use(); settle();
        chk("lu_stall", 32'(stall_D), 1);
        advance();
        load_use(); stg_data_ok = 3'b001; stg_data[0 +: 32] = 32'hABCD; settle();
        chk("lu_stall2", 32'(stall_D), 0);
        chk("lu_fwd", fwd_rs2, 32'hABCD);
        advance();
        long_issue(9); settle(); advance();
        idle(); rs1_D = 9; use_rs1 = 1; settle();
        chk("long_busy", 32'(sb_busy_any), 1);
        chk("long_stall", 32'(stall_D), 1);
        advance();
        complete(9, 32'h5); rs1_D = 9; use_rs1 = 1; settle();
        chk("long_fwd", fwd_rs1, 32'h5);
        chk("long_nostall", 32'(stall_D), 0);
        advance();
        idle(); settle();
        chk("long_drained", 32'(sb_busy_any), 0);
        advance();
        long_issue(9); settle(); advance();
        long_issue(9); lc_valid = 1; lc_rd = 9; settle(); advance();
        idle(); rd_D = 9; wen_D = 1; settle();
        chk("waw_stall", 32'(stall_D), 1);
        advance();
        complete(9, 32'h7); rd_D = 9; wen_D = 1; settle();
        chk("waw_release", 32'(stall_D), 0);
        advance();
        for (int i = 0; i < 3; i++) begin long_issue(3); settle(); advance(); end
        long_issue(3); settle();
        chk("full_stall", 32'(stall_D), 1);
        advance();
        for (int i = 0; i < 3; i++) begin complete(3, 32'(i)); settle(); advance(); end
        idle(); settle();
        chk("full_drained", 32'(sb_busy_any), 0);
        advance();
        idle();
        stg_valid = 3'b011; stg_wen = 3'b011; stg_data_ok = 3'b001;
        stg_rd[0 +: 5] = 0; stg_data[0 +: 32] = 32'h99; stg_rd[5 +: 5] = 7;
        rs1_D = 0; use_rs1 = 1; rs2_D = 7; use_rs2 = 0;
        settle();
        chk("x0_fwd_v", 32'(fwd_v_rs1), 0);
        chk("x0_stall", 32'(stall_D), 0);
        advance();
        for (int i = 0; i < 2; i++) begin long_issue(4); settle(); advance(); end
        idle(); rst = 1; settle(); advance();
        complete(4, 32'h1); settle();
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_busy2", 32'(sb_busy_any), 0);
        advance();
        idle(); settle();
        chk("rst_no_underflow", 32'(sb_busy_any), 0);
        advance();
        for (int i = 0; i < 5; i++) begin load_use(); settle(); advance(); end
        idle(); settle();
        chk("stall_cnt5", stall_cnt, 5);
        advance();
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst        = $urandom_range(0, 199) == 0;
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            use_rs1    = 1'($urandom);
            use_rs2    = 1'($urandom);
            rd_D       = 5'($urandom_range(0, 3));
            wen_D      = $urandom_range(0, 3) != 0;
            long_D     = 1'($urandom);
            issue_fire = $urandom_range(0, 3) != 0;
            flush      = $urandom_range(0, 9) == 0;
            stg_valid  = 3'($urandom);
            stg_wen    = 3'($urandom);
            stg_data_ok = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                stg_rd[i*5 +: 5]    = 5'($urandom_range(0, 3));
                stg_data[i*32 +: 32] = $urandom;
            end
            lc_valid = 1'($urandom);
            lc_rd    = (pend.size() != 0 && $urandom_range(0, 3) != 0)
                       ? pend[$urandom_range(0, pend.size() - 1)] : 5'($urandom_range(0, 3));
            lc_data  = $urandom;
            settle();
            advance();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_fwd.md
Name: hazard_scoreboard_fwd

Overview:
- Parametrised successor to the decode-stage RAW detect/forward unit.
- Combinational forwarding covers an arbitrary number of in-order pipeline stages, selected by NSTAGE.
- A per-register pending-write scoreboard covers variable-latency units (mul/div, non-blocking loads). These units complete out of pipeline order through a completion port.
- Sits beside decode. Drives operand bypass muxes and the decode stall. Also provides a stall performance counter.

Parameters:
- XLEN, 32, data width
- NSTAGE, 3, number of in-order stages after decode offering forwarding; index 0 is youngest (E)
- CW, 2, width of each per-register pending counter; max outstanding long writes per register = 2^CW-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_D  in  5  decode source 1
- rs2_D  in  5  decode source 2
- use_rs1  in  1  decode instruction reads rs1
- use_rs2  in  1  decode instruction reads rs2
- rd_D  in  5  decode destination
- wen_D  in  1  decode instruction writes rd
- long_D  in  1  decode instruction completes via a long-latency unit
- issue_fire  in  1  D->E handshake completed this cycle (valid&ready)
- flush  in  1  cancels the decode instruction this cycle
- stg_valid  in  NSTAGE  stage holds a live instruction
- stg_wen  in  NSTAGE  stage instruction writes rd in-order (0 for long ops)
- stg_rd  in  5*NSTAGE  stage destinations, packed
- stg_data_ok  in  NSTAGE  stage result available (0 for an in-flight load in E)
- stg_data  in  XLEN*NSTAGE  stage results, packed
- lc_valid  in  1  long-latency completion this cycle
- lc_rd  in  5  completing register
- lc_data  in  XLEN  completing value
- stall_D  out  1  hold decode
- fwd_rs1  out  XLEN  bypass value for rs1
- fwd_rs2  out  XLEN  bypass value for rs2
- fwd_v_rs1  out  1  use fwd_rs1 instead of regfile
- fwd_v_rs2  out  1  use fwd_rs2 instead of regfile
- sb_busy_any  out  1  any pending counter nonzero
- stall_cnt  out  32  saturating count of cycles with stall_D=1

Behaviour:
- Reset (rst=1 at clk edge):
  - all 31 pending counters cleared; sb_busy_any=0; stall_cnt=0.
  - Combinational outputs then follow the inputs with an empty scoreboard.
  - A reset taken while long ops are in flight discards their tracking; lc_valid arriving after reset is ignored for an already-zero counter (no underflow).
- Register x0 is never tracked, matched, forwarded or stalled on.
- Per-source resolution, combinational, for s in {rs1,rs2} with use_s=1, s!=0:
  1. Stage match: lowest index i with stg_valid[i] & stg_wen[i] & stg_rd[i]==s.
     - If found and stg_data_ok[i]: fwd_v=1, fwd=stg_data[i].
     - If found and !stg_data_ok[i]: RAW stall.
     - Older stages are not consulted.
  2. Otherwise, if cnt[s]!=0:
     - If lc_valid & lc_rd==s: fwd_v=1, fwd=lc_data.
     - Else RAW stall.
  3. Otherwise fwd_v=0, fwd=0.
  - use_s=0 gives fwd_v=0, fwd=0, and no stall contribution.
- WAW stall: wen_D & rd_D!=0 & !long_D & cnt[rd_D]!=0 & !(lc_valid & lc_rd==rd_D & cnt[rd_D]==1).
- Full stall: wen_D & long_D & rd_D!=0 & cnt[rd_D]==2^CW-1.
- stall_D = RAW(rs1) | RAW(rs2) | WAW | full. Deasserted whenever flush=1.
- Scoreboard update, at the clk edge. Let inc = issue_fire & !flush & !stall_D & wen_D & long_D & rd_D!=0.
  - dec applies when lc_valid & lc_rd!=0 & cnt[lc_rd]!=0.
  - Same register with both inc and dec: count unchanged.
  - Different registers: both apply.
  - Counters never wrap; the full stall guarantees no overflow.
- sb_busy_any reflects registered counter state and has a one-cycle lag after an inc/dec.
- stall_cnt increments when stall_D=1 and !rst, and saturates at 0xFFFFFFFF.
- Flush does not clear the scoreboard. Issued long ops always complete.
- Ports are packed with stage i at bits [i*W +: W].

Test Plan:
- Back-to-back ALU: stage0 valid, wen, rd=5, data_ok, data=0x11; stage2 rd=5, data=0x22; rs1_D=5 -> fwd_v_rs1=1, fwd_rs1=0x11, stall_D=0.
- Load-use: stage0 rd=7, data_ok=0; rs2_D=7, use_rs2=1 -> stall_D=1; next cycle with data_ok=1, data=0xABCD -> stall_D=0, fwd_rs2=0xABCD.
- Long op: issue div rd=9 (long_D=1) -> cnt[9]=1 and sb_busy_any=1 the next cycle. Dependent rs1=9 stalls until lc_valid, lc_rd=9, lc_data=0x5 -> same cycle fwd_rs1=0x5, stall_D=0; cnt[9]=0 after the edge.
- Simultaneous inc/dec on rd=9 with cnt[9]=1 -> cnt stays 1. Short op writing x9 while cnt[9]=1 -> WAW stall. Three long issues to x3 with CW=2 -> 4th stalls (full).
- x0 and use flags: rs1_D=0 with stage0 rd=0 -> no forward, no stall. use_rs2=0 with a matching stall condition -> no stall.
- Reset mid-flight: cnt[4]=2, assert rst -> counters 0, stall_cnt=0; a later lc_valid rd=4 leaves cnt[4]=0. stall_cnt counts exactly 5 after 5 stall cycles.
